// File: rtl/spike_event_queue.sv
// Multi-lane spike-event FIFO: lane-priority admission into a circular buffer, one pop per cycle.
// Optional saturating drop counter enabled by defining SPIKE_QUEUE_DROP_STATS_EN.
module spike_event_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PTRBITS = 4,
  parameter int unsigned TAGBITS = 4,
  parameter int unsigned LANES   = 2
) (
  input  logic                       clk,
  input  logic                       asyn_reset,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*TAGBITS-1:0]   in_tag,
  input  logic                       deq,
  output logic [TAGBITS-1:0]         out_tag,
  output logic                       out_valid,
  output logic                       empty,
  output logic                       full,
  output logic [PTRBITS:0]           count,
  output logic [LANES-1:0]           accepted,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned CW = PTRBITS + 1;
  localparam int unsigned SW = PTRBITS + 2;

  logic [TAGBITS-1:0] mem [DEPTH];
  logic [PTRBITS-1:0] rd_ptr;
  logic [PTRBITS-1:0] wr_ptr;
  logic [CW-1:0]      count_q;

  logic               deq_eff;
  logic [SW-1:0]      space;
  logic [SW-1:0]      n_valid;
  logic [CW-1:0]      n_acc;
  logic [PTRBITS-1:0] waddr [LANES];

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = ~empty;
  assign out_tag   = empty ? '0 : mem[rd_ptr];

  // Accepted lanes always form a prefix of the valid lanes, so a lane's write
  // rank equals the number of valid lanes below it.
  always_comb begin
    deq_eff  = deq & ~empty;
    space    = SW'(DEPTH) - SW'(count_q) + SW'(deq_eff);
    n_valid  = '0;
    n_acc    = '0;
    accepted = '0;
    for (int i = 0; i < LANES; i++) begin
      waddr[i]    = wr_ptr + n_valid[PTRBITS-1:0];
      accepted[i] = in_valid[i] && (n_valid < space);
      n_valid     = n_valid + SW'(in_valid[i]);
      n_acc       = n_acc + CW'(accepted[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        mem[j] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (accepted[i]) begin
          mem[waddr[i]] <= in_tag[i*TAGBITS +: TAGBITS];
        end
      end
      wr_ptr  <= wr_ptr + n_acc[PTRBITS-1:0];
      rd_ptr  <= rd_ptr + PTRBITS'(deq_eff);
      count_q <= count_q + n_acc - CW'(deq_eff);
    end
  end

`ifdef SPIKE_QUEUE_DROP_STATS_EN
  logic [15:0] drop_q;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(n_valid - SW'(n_acc));
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed self-checking bench for spike_event_queue at DEPTH=4, LANES=2.
// Drop-count expectations follow SPIKE_QUEUE_DROP_STATS_EN.
module tb_spike_event_queue;

`ifdef SPIKE_QUEUE_DROP_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       asyn_reset = 1'b0;
  logic [1:0] in_valid = '0;
  logic [7:0] in_tag = '0;
  logic       deq = 1'b0;
  logic [3:0] out_tag;
  logic       out_valid;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic [1:0] accepted;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] drops = '0;

  spike_event_queue #(
    .DEPTH(4),
    .PTRBITS(2),
    .TAGBITS(4),
    .LANES(2)
  ) dut (
    .clk(clk),
    .asyn_reset(asyn_reset),
    .in_valid(in_valid),
    .in_tag(in_tag),
    .deq(deq),
    .out_tag(out_tag),
    .out_valid(out_valid),
    .empty(empty),
    .full(full),
    .count(count),
    .accepted(accepted),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1,
                       input logic d);
    in_valid = v;
    in_tag   = {t1, t0};
    deq      = d;
    #1;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    drive(2'b11, 4'h1, 4'h2, 1'b1);
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    asyn_reset = 1'b0;
    drive(2'b00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_lane_order();
    drive(2'b11, 4'h3, 4'h5, 1'b0);
    checks++; if (accepted !== 2'b11) begin errors++; $display("FAIL order_accept: got %b expected 11", accepted); end
    tick();
    drive(2'b00, 4'h0, 4'h0, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL order_count: got %0d expected 2", count); end
    checks++; if (out_tag !== 4'h3) begin errors++; $display("FAIL order_head0: got %h expected 3", out_tag); end
    drive(2'b00, 4'h0, 4'h0, 1'b1);
    tick();
    checks++; if (out_tag !== 4'h5) begin errors++; $display("FAIL order_head1: got %h expected 5", out_tag); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b expected 1", empty); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL order_empty_tag: got %h expected 0", out_tag); end
    // deq while empty must be a no-op
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL order_underflow: got %0d expected 0", count); end
    drive(2'b00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_overflow_and_full_deq();
    drive(2'b11, 4'h1, 4'h2, 1'b0);
    tick();
    drive(2'b01, 4'h3, 4'h0, 1'b0);
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL ovf_fill: got %0d expected 3", count); end
    drive(2'b11, 4'hA, 4'hB, 1'b0);
    checks++; if (accepted !== 2'b01) begin errors++; $display("FAIL ovf_accept: got %b expected 01", accepted); end
    tick();
    drops = drops + 16'd1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (drop_cnt !== (StatsEn ? drops : 16'd0)) begin errors++; $display("FAIL ovf_drop: got %0d expected %0d", drop_cnt, StatsEn ? drops : 16'd0); end
    // Full with deq: exactly lane 0 fits
    drive(2'b11, 4'h7, 4'h8, 1'b1);
    checks++; if (accepted !== 2'b01) begin errors++; $display("FAIL fdeq_accept: got %b expected 01", accepted); end
    tick();
    drops = drops + 16'd1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fdeq_count: got %0d expected 4", count); end
    checks++; if (out_tag !== 4'h2) begin errors++; $display("FAIL fdeq_head: got %h expected 2", out_tag); end
    checks++; if (drop_cnt !== (StatsEn ? drops : 16'd0)) begin errors++; $display("FAIL fdeq_drop: got %0d expected %0d", drop_cnt, StatsEn ? drops : 16'd0); end
    // Full, no deq: both lanes rejected
    drive(2'b11, 4'hC, 4'hD, 1'b0);
    checks++; if (accepted !== 2'b00) begin errors++; $display("FAIL full_accept: got %b expected 00", accepted); end
    tick();
    drops = drops + 16'd2;
    checks++; if (drop_cnt !== (StatsEn ? drops : 16'd0)) begin errors++; $display("FAIL full_drop: got %0d expected %0d", drop_cnt, StatsEn ? drops : 16'd0); end
    begin
      logic [3:0] exp_seq [4];
      exp_seq = '{4'h2, 4'h3, 4'hA, 4'h7};
      drive(2'b00, 4'h0, 4'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
        checks++; if (out_tag !== exp_seq[k]) begin errors++; $display("FAIL drain_%0d: got %h expected %h", k, out_tag, exp_seq[k]); end
        tick();
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    drive(2'b00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_enq_empty_deq();
    drive(2'b11, 4'hC, 4'hD, 1'b1);
    checks++; if (accepted !== 2'b11) begin errors++; $display("FAIL edeq_accept: got %b expected 11", accepted); end
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL edeq_count: got %0d expected 2", count); end
    checks++; if (out_tag !== 4'hC) begin errors++; $display("FAIL edeq_head: got %h expected C", out_tag); end
    drive(2'b00, 4'h0, 4'h0, 1'b1);
    tick();
    checks++; if (out_tag !== 4'hD) begin errors++; $display("FAIL edeq_head1: got %h expected D", out_tag); end
    tick();
    drive(2'b00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int j = 0; j < 10; j++) begin
      drive(2'b01, 4'(j), 4'h0, j >= 2);
      if (j >= 2) begin
        checks++; if (out_tag !== 4'(j - 2)) begin errors++; $display("FAIL wrap_pop_%0d: got %h expected %h", j - 2, out_tag, 4'(j - 2)); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid_%0d: got %b expected 1", j, out_valid); end
      end
      tick();
    end
    drive(2'b00, 4'h0, 4'h0, 1'b1);
    for (int j = 8; j < 10; j++) begin
      checks++; if (out_tag !== 4'(j)) begin errors++; $display("FAIL wrap_pop_%0d: got %h expected %h", j, out_tag, 4'(j)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid: got %b expected 0", out_valid); end
    drive(2'b00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 4'h1, 4'h2, 1'b0);
    tick();
    drive(2'b01, 4'h3, 4'h0, 1'b0);
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_fill: got %0d expected 3", count); end
    asyn_reset = 1'b1;
    drive(2'b11, 4'h5, 4'h6, 1'b1);
    tick();
    asyn_reset = 1'b0;
    drops = '0;
    drive(2'b00, 4'h0, 4'h0, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b expected 1", empty); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rmid_tag: got %h expected 0", out_tag); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rmid_drop: got %0d expected 0", drop_cnt); end
    drive(2'b01, 4'h9, 4'h0, 1'b0);
    tick();
    drive(2'b00, 4'h0, 4'h0, 1'b0);
    checks++; if (out_tag !== 4'h9) begin errors++; $display("FAIL rmid_push: got %h expected 9", out_tag); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rmid_push_count: got %0d expected 1", count); end
  endtask

  initial begin
    test_reset();
    test_lane_order();
    test_overflow_and_full_deq();
    test_enq_empty_deq();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_event_queue.md
# spike_event_queue

Multi-lane, parametrised spike-event FIFO for the Izhikevich graph accelerator. Up to LANES neuron units can post fire tags in one cycle. One tag per cycle is drained toward the synapse-dispatch stage. The queue is a circular buffer with independent read and write pointers, lane-priority admission when space runs short, and optional drop statistics.

## Interface
- DEPTH, 16: number of entries; must equal 2**PTRBITS.
- PTRBITS, 4: pointer width.
- TAGBITS, 4: neuron tag width.
- LANES, 2: enqueue lanes; 1 ≤ LANES ≤ DEPTH.

- clk  in  1  rising-edge clock.
- asyn_reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  in  LANES  bit i set means lane i presents a tag this cycle.
- in_tag  in  LANES*TAGBITS  lane i tag at [i*TAGBITS +: TAGBITS].
- deq  in  1  pop the head entry this cycle.
- out_tag  out  TAGBITS  head entry (first-word fall-through); 0 when empty.
- out_valid  out  1  equals !empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  PTRBITS+1  occupied entries, 0..DEPTH.
- accepted  out  LANES  combinational per-lane accept mask for the current cycle.
- drop_cnt  out  16  saturating count of rejected lane tags (see Configuration).

## Operation
- State: mem[0..DEPTH-1], rd_ptr, wr_ptr (PTRBITS each, wrap modulo DEPTH), count.
- deq_eff = deq & !empty. A deq while empty is ignored; nothing changes and nothing is flagged.
- space = DEPTH - count + deq_eff. A pop in the same cycle frees a slot for enqueue.
- Admission: lane i is accepted iff in_valid[i] = 1 and the number of valid lanes with index < i is less than space. The lowest-index lanes always win.
- n_acc = popcount(accepted). Accepted lane of rank k (k-th accepted, counting from lane 0) is written to mem[(wr_ptr + k) mod DEPTH].
- Update per clock edge:
  - wr_ptr += n_acc.
  - rd_ptr += deq_eff.
  - count += n_acc - deq_eff.
- Rejected valid lanes are dropped silently. The upstream neuron does not retry.
- out_tag = mem[rd_ptr] when !empty, else 0. This output is combinational from state; no combinational path from in_* to out_tag.
- accepted depends combinationally on in_valid, deq and count.
- Reset: rd_ptr = wr_ptr = count = 0, all mem entries = 0, drop_cnt = 0. Enqueue and dequeue requests in the reset cycle are discarded.

## Timing
- All state changes on the rising edge of clk only.
- Reset values: out_tag = 0, out_valid = 0, empty = 1, full = 0, count = 0, drop_cnt = 0. accepted reflects inputs, but nothing is written during reset.
- Enqueue latency: a tag accepted in cycle N is visible on out_tag in cycle N+1 if it is at the head. There is no same-cycle bypass.
- Enqueue into an empty queue with deq = 1 in the same cycle: the deq is ignored and all accepted tags are stored.
- Full queue with deq = 1: one slot is freed, so lane 0 (or the lowest valid lane) is accepted. count stays DEPTH if exactly one lane is accepted.
- Wrap-around: pointers roll from DEPTH-1 to 0 without a bubble. Multi-lane writes may straddle the wrap.
- count never exceeds DEPTH and never underflows.

## Configuration
- SPIKE_QUEUE_DROP_STATS_EN defined:
  - drop_cnt increments by (popcount(in_valid) - n_acc) each non-reset cycle.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: drop_cnt is tied to 0 and no counter logic is synthesised. Admission behaviour is identical.

## Test plan
- Reset: drive asyn_reset = 1 for one edge with in_valid = 2'b11 and deq = 1. Required: count = 0, empty = 1, full = 0, out_tag = 0, drop_cnt = 0.
- Lane ordering (DEPTH = 4, LANES = 2): in_valid = 2'b11 with lane0 = 4'h3, lane1 = 4'h5. Required: count = 2 and out_tag = 3 next cycle; after deq, out_tag = 5; after a second deq, empty = 1.
- Overflow, no deq: fill to count = 3, then in_valid = 2'b11 with lane0 = 4'hA, lane1 = 4'hB. Required:
  - accepted = 2'b01.
  - Next cycle: count = 4, full = 1, drop_cnt = 1 (0 with the macro undefined).
  - Draining returns A last.
- Full with deq: at count = 4, deq = 1 and in_valid = 2'b11 with lane0 = 4'h7, lane1 = 4'h8. Required:
  - accepted = 2'b01 and count = 4.
  - drop_cnt increments by 1.
  - The head advances and 7 becomes the tail.
- Wrap-around: single-lane push of 0..9, interleaved with pops keeping count ≤ 3. Required: pops return 0..9 in order with no loss; out_valid drops only when count = 0.
- Reset mid-operation: at count = 3, asyn_reset = 1 with in_valid = 2'b11 and deq = 1. Required: count = 0, empty = 1 and out_tag = 0 next cycle. A subsequent single push of 4'h9 is read back as 9.
